// File: rtl/arbiter_rr_wormhole_pkg.sv
// rtl/arbiter_rr_wormhole_pkg.sv - port indices, port count and FSM state codes for the wormhole arbiter
package arbiter_rr_wormhole_pkg;

  localparam int NUM_PORTS = 7;

  localparam logic [2:0] IDX_IP = 3'd0;
  localparam logic [2:0] IDX_W  = 3'd1;
  localparam logic [2:0] IDX_E  = 3'd2;
  localparam logic [2:0] IDX_S  = 3'd3;
  localparam logic [2:0] IDX_N  = 3'd4;
  localparam logic [2:0] IDX_D  = 3'd5;
  localparam logic [2:0] IDX_U  = 3'd6;

  localparam logic [0:0] ARB_ST_IDLE   = 1'b0;
  localparam logic [0:0] ARB_ST_LOCKED = 1'b1;

  // Pointer advance after a release: the port after the winner, U wrapping to IP.
  function automatic logic [2:0] rr_next(input logic [2:0] g);
    return (g >= IDX_U) ? IDX_IP : g + 3'd1;
  endfunction

endpackage

// File: rtl/arbiter_rr_wormhole_rr_pick.sv
// rtl/arbiter_rr_wormhole_rr_pick.sv - combinational round-robin pick over 7 requesters
module rr_pick_7
  import arbiter_rr_wormhole_pkg::*;
(
  input  logic [6:0] eligible_i,
  input  logic [2:0] rr_ptr_i,
  output logic [6:0] onehot_o,
  output logic [2:0] idx_o,
  output logic       any_o
);

  logic [2:0] start;
  logic [3:0] sum;
  logic [2:0] pos;

  always_comb begin
    onehot_o = '0;
    idx_o    = IDX_IP;
    any_o    = 1'b0;
    sum      = '0;
    pos      = '0;
    // Pointer value 7 cannot be produced, but is folded onto IP if it ever appears.
    start    = (rr_ptr_i > IDX_U) ? IDX_IP : rr_ptr_i;
    for (int k = 0; k < 7; k++) begin
      sum = {1'b0, start} + 4'(k);
      pos = (sum >= 4'd7) ? 3'(sum - 4'd7) : sum[2:0];
      if (!any_o && eligible_i[pos]) begin
        any_o         = 1'b1;
        idx_o         = pos;
        onehot_o[pos] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/arbiter_rr_wormhole.sv
// rtl/arbiter_rr_wormhole.sv - 7-port round-robin output arbiter holding grant for a wormhole packet
// Optional lock timeout enabled by defining ARB_LOCK_TIMEOUT_EN.
module arbiter_rr_wormhole
  import arbiter_rr_wormhole_pkg::*;
#(
  parameter int NUM_PORTS      = 7,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_PORTS-1:0]           reqs,
  input  logic [NUM_PORTS-1:0]           fifo_available,
  input  logic [NUM_PORTS*NUM_PORTS-1:0] route_req,
  input  logic                           flit_fire,
  input  logic                           tail_fire,
  output logic [NUM_PORTS-1:0]           grants,
  output logic [NUM_PORTS-1:0]           forwards,
  output logic                           locked,
  output logic                           timeout_o
);

  logic [0:0] state_q, state_d;
  logic [6:0] grants_q, grants_d;
  logic [6:0] fwd_q, fwd_d;
  logic [2:0] ptr_q, ptr_d;
  logic [2:0] gidx_q, gidx_d;

  logic [6:0] eligible;
  logic [6:0] pick_onehot;
  logic [2:0] pick_idx;
  logic       pick_any;
  logic [6:0] pick_route;
  logic       force_rel;
  logic       release_now;

  always_comb begin
    eligible   = '0;
    pick_route = '0;
    for (int i = 0; i < 7; i++) begin
      eligible[i] = reqs[i] & (|(route_req[7*i +: 7] & fifo_available));
      if (pick_onehot[i]) begin
        pick_route = pick_route | route_req[7*i +: 7];
      end
    end
  end

  rr_pick_7 u_pick (
    .eligible_i (eligible),
    .rr_ptr_i   (ptr_q),
    .onehot_o   (pick_onehot),
    .idx_o      (pick_idx),
    .any_o      (pick_any)
  );

  assign release_now = (state_q == ARB_ST_LOCKED) &&
                       ((flit_fire && tail_fire) || force_rel);

  always_comb begin
    state_d  = state_q;
    grants_d = grants_q;
    fwd_d    = fwd_q;
    ptr_d    = ptr_q;
    gidx_d   = gidx_q;
    if (state_q == ARB_ST_IDLE) begin
      if (pick_any) begin
        grants_d = pick_onehot;
        fwd_d    = pick_route & fifo_available;
        gidx_d   = pick_idx;
        state_d  = ARB_ST_LOCKED;
      end
    end else if (release_now) begin
      // Release cycle never re-arbitrates, leaving one idle cycle between packets.
      grants_d = '0;
      fwd_d    = '0;
      ptr_d    = rr_next(gidx_q);
      state_d  = ARB_ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ARB_ST_IDLE;
      grants_q <= '0;
      fwd_q    <= '0;
      ptr_q    <= IDX_IP;
      gidx_q   <= IDX_IP;
    end else begin
      state_q  <= state_d;
      grants_q <= grants_d;
      fwd_q    <= fwd_d;
      ptr_q    <= ptr_d;
      gidx_q   <= gidx_d;
    end
  end

`ifdef ARB_LOCK_TIMEOUT_EN
  localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT_CYCLES);

  logic [7:0] to_cnt_q;
  logic       timeout_q;

  // The pulse is raised as the counter reaches the limit; the release follows one edge later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      if ((state_q == ARB_ST_IDLE) || flit_fire || release_now) begin
        to_cnt_q <= '0;
      end else begin
        to_cnt_q <= to_cnt_q + 8'd1;
      end
      timeout_q <= (state_q == ARB_ST_LOCKED) && !flit_fire &&
                   (to_cnt_q == TO_LIMIT - 8'd1);
    end
  end

  assign force_rel = (state_q == ARB_ST_LOCKED) && (to_cnt_q == TO_LIMIT);
  assign timeout_o = timeout_q;
`else
  assign force_rel = 1'b0;
  assign timeout_o = 1'b0;
`endif

  assign grants   = grants_q;
  assign forwards = fwd_q;
  assign locked   = state_q[0];

endmodule

// File: tb/tb_arbiter_rr_wormhole.sv
// tb/tb_arbiter_rr_wormhole.sv - self-checking bench for arbiter_rr_wormhole (honours ARB_LOCK_TIMEOUT_EN)
module tb_arbiter_rr_wormhole;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  reqs = '0;
  logic [6:0]  fifo_available = '0;
  logic [48:0] route_req = '0;
  logic        flit_fire = 1'b0;
  logic        tail_fire = 1'b0;
  logic [6:0]  grants;
  logic [6:0]  forwards;
  logic        locked;
  logic        timeout_o;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [6:0] reqs;
    logic [6:0] fifo;
    logic [6:0] dir;
    logic       flit;
    logic       tail;
    logic [6:0] eg;
    logic [6:0] ef;
    logic       el;
  } vec_t;

  vec_t vecs[22];

  always #5 clk = ~clk;

  arbiter_rr_wormhole #(.NUM_PORTS(7), .TIMEOUT_CYCLES(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .reqs           (reqs),
    .fifo_available (fifo_available),
    .route_req      (route_req),
    .flit_fire      (flit_fire),
    .tail_fire      (tail_fire),
    .grants         (grants),
    .forwards       (forwards),
    .locked         (locked),
    .timeout_o      (timeout_o)
  );

  task automatic chk(input string name, input logic [6:0] act, input logic [6:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    reqs = '0; fifo_available = '0; route_req = '0; flit_fire = 1'b0; tail_fire = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic fire(input logic tail);
    flit_fire = 1'b1; tail_fire = tail;
    step();
    flit_fire = 1'b0; tail_fire = 1'b0;
  endtask

  initial begin
    // Round-robin over all ports with single-flit packets, all routed E.
    for (int k = 0; k < 8; k++) begin
      vecs[2*k]   = '{7'h7F, 7'h7F, 7'h04, 1'b0, 1'b0, 7'd1 << (k % 7), 7'h04, 1'b1};
      vecs[2*k+1] = '{7'h7F, 7'h7F, 7'h04, 1'b1, 1'b1, 7'h00, 7'h00, 1'b0};
    end
    vecs[16] = '{7'h00, 7'h7F, 7'h04, 1'b1, 1'b1, 7'h00, 7'h00, 1'b0};
    vecs[17] = '{7'h00, 7'h7F, 7'h04, 1'b1, 1'b1, 7'h00, 7'h00, 1'b0};
    vecs[18] = '{7'h7F, 7'h7F, 7'h04, 1'b0, 1'b0, 7'h02, 7'h04, 1'b1};
    vecs[19] = '{7'h7F, 7'h7F, 7'h04, 1'b0, 1'b1, 7'h02, 7'h04, 1'b1};
    vecs[20] = '{7'h7F, 7'h7F, 7'h04, 1'b1, 1'b0, 7'h02, 7'h04, 1'b1};
    vecs[21] = '{7'h7F, 7'h7F, 7'h04, 1'b1, 1'b1, 7'h00, 7'h00, 1'b0};

    repeat (2) @(posedge clk);
    #1;
    chk("reset_grants", grants, 7'h00);
    chk("reset_forwards", forwards, 7'h00);
    chk("reset_locked", {6'd0, locked}, 7'd0);
    chk("reset_timeout", {6'd0, timeout_o}, 7'd0);
    rst_n = 1'b1;

    for (int v = 0; v < 22; v++) begin
      reqs = vecs[v].reqs; fifo_available = vecs[v].fifo; route_req = {7{vecs[v].dir}};
      flit_fire = vecs[v].flit; tail_fire = vecs[v].tail;
      step();
      chk($sformatf("vec%0d_grants", v), grants, vecs[v].eg);
      chk($sformatf("vec%0d_forwards", v), forwards, vecs[v].ef);
      chk($sformatf("vec%0d_locked", v), {6'd0, locked}, {6'd0, vecs[v].el});
    end

    // Asynchronous reset mid-packet after the pointer has advanced past IP.
    do_reset();
    reqs = 7'h7F; fifo_available = 7'h7F; route_req = {7{7'h04}};
    step();
    fire(1'b1);
    step();
    chk("t1_pre_grants", grants, 7'h02);
    #2 rst_n = 1'b0;
    #1;
    chk("t1_async_grants", grants, 7'h00);
    chk("t1_async_forwards", forwards, 7'h00);
    chk("t1_async_locked", {6'd0, locked}, 7'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    step();
    chk("t1_ptr_zero_grants", grants, 7'h01);

    // Lock hold: W routed N, 4-flit packet while IP keeps requesting.
    do_reset();
    fifo_available = 7'h7F;
    reqs = 7'b0000010; route_req = '0; route_req[13:7] = 7'h10;
    step();
    chk("t3_grant_w", grants, 7'h02);
    chk("t3_fwd_n", forwards, 7'h10);
    reqs = 7'b0000011; route_req[6:0] = 7'h04;
    for (int f = 0; f < 4; f++) begin
      chk($sformatf("t3_hold%0d", f), grants, 7'h02);
      fire(f == 3);
    end
    chk("t3_released", grants, 7'h00);
    chk("t3_released_locked", {6'd0, locked}, 7'd0);
    step();
    chk("t3_ip_next", grants, 7'h01);
    chk("t3_ip_fwd", forwards, 7'h04);

    // Eligibility: IP's only route (S) is full, E's route (U) is free.
    do_reset();
    reqs = 7'b0000101; fifo_available = 7'b1110111;
    route_req = '0; route_req[6:0] = 7'h08; route_req[20:14] = 7'h40;
    step();
    chk("t4_grant_e", grants, 7'h04);
    chk("t4_fwd_u", forwards, 7'h40);

    // Wrap: D packet moves the pointer to U, then U beats IP, then IP follows.
    do_reset();
    fifo_available = 7'h7F; route_req = {7{7'h04}};
    reqs = 7'b0100000;
    step();
    chk("t5_grant_d", grants, 7'h20);
    fire(1'b1);
    reqs = 7'b1000001;
    step();
    chk("t5_grant_u", grants, 7'h40);
    fire(1'b1);
    chk("t5_u_released", grants, 7'h00);
    step();
    chk("t5_grant_ip", grants, 7'h01);

    // Lock with no flit movement.
    do_reset();
    fifo_available = 7'h7F; route_req = {7{7'h04}}; reqs = 7'h01;
    step();
    chk("t6_locked", {6'd0, locked}, 7'd1);
`ifdef ARB_LOCK_TIMEOUT_EN
    for (int c = 1; c <= 3; c++) begin
      step();
      chk($sformatf("t6_wait%0d_timeout", c), {6'd0, timeout_o}, 7'd0);
      chk($sformatf("t6_wait%0d_locked", c), {6'd0, locked}, 7'd1);
    end
    step();
    chk("t6_pulse_timeout", {6'd0, timeout_o}, 7'd1);
    chk("t6_pulse_locked", {6'd0, locked}, 7'd1);
    step();
    chk("t6_after_timeout", {6'd0, timeout_o}, 7'd0);
    chk("t6_after_locked", {6'd0, locked}, 7'd0);
    chk("t6_after_grants", grants, 7'h00);
`else
    begin
      int pulses = 0;
      for (int c = 0; c < 100; c++) begin
        step();
        if (timeout_o !== 1'b0) pulses++;
      end
      chk("t6_no_timeout_pulse", 7'(pulses), 7'd0);
      chk("t6_still_locked", {6'd0, locked}, 7'd1);
      chk("t6_still_granted", grants, 7'h01);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
